// File: rtl/knap_search_multi.sv
// Exhaustive multi-constraint 0/1 knapsack searcher: walks all 2^N selections in
// Gray-code order, keeps running totals, and streams qualifying selections out.
module knap_search_multi #(
  parameter int N  = 17,
  parameter int W  = 5,
  parameter int TW = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ld_en,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ld_idx,
  input  logic [W-1:0]                   ld_value,
  input  logic [W-1:0]                   ld_weight,
  input  logic [W-1:0]                   ld_volume,
  input  logic [TW-1:0]                  min_value,
  input  logic [TW-1:0]                  max_weight,
  input  logic [TW-1:0]                  max_volume,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           sol_valid,
  input  logic                           sol_ready,
  output logic [N-1:0]                   sol_sel,
  output logic [N:0]                     sol_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [W-1:0]  tab_value  [N];
  logic [W-1:0]  tab_weight [N];
  logic [W-1:0]  tab_volume [N];

  logic [TW-1:0] thr_min_value, thr_max_weight, thr_max_volume;
  logic [TW-1:0] tot_value, tot_weight, tot_volume;
  logic [N-1:0]  sel, step, step_inc, mask;

  logic          hit, slot_free, stall, last;
  logic [W-1:0]  d_value, d_weight, d_volume;
  logic          d_set;

  assign hit       = (tot_value >= thr_min_value) && (tot_weight <= thr_max_weight) &&
                     (tot_volume <= thr_max_volume);
  assign slot_free = !sol_valid || sol_ready;
  assign stall     = hit && !slot_free;
  assign last      = &step;

  // The bit that becomes set when incrementing step is the Gray-code bit to flip.
  assign step_inc  = step + N'(1);
  assign mask      = step_inc & ~step;

  always_comb begin
    d_value  = '0;
    d_weight = '0;
    d_volume = '0;
    d_set    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mask[i]) begin
        d_value  = tab_value[i];
        d_weight = tab_weight[i];
        d_volume = tab_volume[i];
        d_set    = !sel[i];
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (!stall && last) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        tab_value[i]  <= '0;
        tab_weight[i] <= '0;
        tab_volume[i] <= '0;
      end
      thr_min_value  <= '0;
      thr_max_weight <= '0;
      thr_max_volume <= '0;
      tot_value      <= '0;
      tot_weight     <= '0;
      tot_volume     <= '0;
      sel            <= '0;
      step           <= '0;
      sol_valid      <= 1'b0;
      sol_sel        <= '0;
      sol_count      <= '0;
    end else if (state != RUN) begin
      if (ld_en && (int'(ld_idx) < N)) begin
        tab_value[ld_idx]  <= ld_value;
        tab_weight[ld_idx] <= ld_weight;
        tab_volume[ld_idx] <= ld_volume;
      end
      if (sol_valid && sol_ready) sol_valid <= 1'b0;
      if (start) begin
        thr_min_value  <= min_value;
        thr_max_weight <= max_weight;
        thr_max_volume <= max_volume;
        tot_value      <= '0;
        tot_weight     <= '0;
        tot_volume     <= '0;
        sel            <= '0;
        step           <= '0;
        sol_count      <= '0;
        sol_valid      <= 1'b0;
      end
    end else begin
      if (hit && slot_free) begin
        sol_sel   <= sel;
        sol_valid <= 1'b1;
        sol_count <= sol_count + (N+1)'(1);
      end else if (sol_valid && sol_ready) begin
        sol_valid <= 1'b0;
      end
      if (!stall && !last) begin
        step <= step_inc;
        sel  <= sel ^ mask;
        if (d_set) begin
          tot_value  <= tot_value  + TW'(d_value);
          tot_weight <= tot_weight + TW'(d_weight);
          tot_volume <= tot_volume + TW'(d_volume);
        end else begin
          tot_value  <= tot_value  - TW'(d_value);
          tot_weight <= tot_weight - TW'(d_weight);
          tot_volume <= tot_volume - TW'(d_volume);
        end
      end
    end
  end

endmodule

// File: tb/tb_knap_search_multi.sv
// Scoreboard bench for knap_search_multi: a direct-sum model predicts the Gray-order
// solution stream; a negedge monitor checks every accepted selection and stall hold.
module tb_knap_search_multi;

  localparam int N  = 3;
  localparam int W  = 5;
  localparam int TW = 8;
  localparam int IW = 2;
  localparam int NS = 1 << N;

  logic          clk, rst, ld_en, start, sol_ready;
  logic [IW-1:0] ld_idx;
  logic [W-1:0]  ld_value, ld_weight, ld_volume;
  logic [TW-1:0] min_value, max_weight, max_volume;
  logic          busy, done, sol_valid;
  logic [N-1:0]  sol_sel;
  logic [N:0]    sol_count;

  knap_search_multi #(.N(N), .W(W), .TW(TW)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_value(ld_value), .ld_weight(ld_weight), .ld_volume(ld_volume),
    .min_value(min_value), .max_weight(max_weight), .max_volume(max_volume),
    .start(start), .busy(busy), .done(done), .sol_valid(sol_valid),
    .sol_ready(sol_ready), .sol_sel(sol_sel), .sol_count(sol_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] exp_q[$];
  int m_val[N], m_wt[N], m_vol[N];

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endfunction

  // Enumerate selections in Gray order, summing each from scratch.
  function automatic int push_expected(int minv, int maxw, int maxvol);
    int cnt = 0;
    for (int k = 0; k < NS; k++) begin
      int g = k ^ (k >> 1);
      int sv = 0, sw = 0, so = 0;
      for (int i = 0; i < N; i++) begin
        if ((g >> i) & 1) begin
          sv += m_val[i]; sw += m_wt[i]; so += m_vol[i];
        end
      end
      if (sv >= minv && sw <= maxw && so <= maxvol) begin
        exp_q.push_back(N'(g));
        cnt++;
      end
    end
    return cnt;
  endfunction

  logic         prev_stall = 1'b0;
  logic [N-1:0] prev_sel   = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(sol_valid), 1);
        chk("hold_sel", int'(sol_sel), int'(prev_sel));
      end
      if (sol_valid && sol_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_sol: got sel %0d required none", sol_sel);
        end else begin
          logic [N-1:0] e;
          e = exp_q.pop_front();
          chk("sol_sel", int'(sol_sel), int'(e));
        end
      end
      prev_stall = sol_valid && !sol_ready;
      prev_sel   = sol_sel;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input int v, input int w, input int vol);
    ld_en = 1'b1; ld_idx = IW'(idx);
    ld_value = W'(v); ld_weight = W'(w); ld_volume = W'(vol);
    tick();
    ld_en = 1'b0;
    if (idx < N) begin
      m_val[idx] = v; m_wt[idx] = w; m_vol[idx] = vol;
    end
  endtask

  task automatic load_basic();
    load(0, 10, 5, 5);
    load(1, 20, 30, 10);
    load(2, 15, 10, 40);
  endtask

  // mode 0: ready=1; 1: random ready; 2: ready low for 10 cycles; 3: ld_en/start poked mid-run
  task automatic run_search(input int minv, input int maxw, input int maxvol,
                            input int mode, input int exp_lat);
    int cnt, lat, t;
    cnt = push_expected(minv, maxw, maxvol);
    min_value = TW'(minv); max_weight = TW'(maxw); max_volume = TW'(maxvol);
    sol_ready = (mode != 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("done_after_start", int'(done), 0);
    lat = 0;
    while (!done && lat < 1000) begin
      case (mode)
        1: sol_ready = 1'($urandom_range(0, 1));
        2: sol_ready = (lat >= 10);
        3: if (lat == 2) begin
             ld_en = 1'b1; ld_idx = '0;
             ld_value = 5'd31; ld_weight = '0; ld_volume = '0;
             start = 1'b1;
           end
        default: ;
      endcase
      tick();
      lat++;
      ld_en = 1'b0;
      start = 1'b0;
    end
    chk("done_reached", int'(done), 1);
    if (exp_lat >= 0) chk("run_cycles", lat, exp_lat);
    sol_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      tick();
      t++;
    end
    chk("drain", exp_q.size(), 0);
    chk("sol_count", int'(sol_count), cnt);
    tick();
    chk("done_holds", int'(done), 1);
    chk("count_holds", int'(sol_count), cnt);
  endtask

  initial begin
    int dummy;
    rst = 1'b1; ld_en = 1'b0; start = 1'b0; sol_ready = 1'b1;
    ld_idx = '0; ld_value = '0; ld_weight = '0; ld_volume = '0;
    min_value = '0; max_weight = '0; max_volume = '0;
    for (int i = 0; i < N; i++) begin m_val[i] = 0; m_wt[i] = 0; m_vol[i] = 0; end
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(sol_valid), 0);
    chk("rst_sel", int'(sol_sel), 0);
    chk("rst_count", int'(sol_count), 0);

    load(3, 31, 31, 31);
    load_basic();
    run_search(25, 40, 50, 0, NS);
    chk("basic_count", int'(sol_count), 3);
    run_search(25, 40, 50, 2, 14);
    chk("bp_count", int'(sol_count), 3);
    run_search(100, 40, 50, 0, NS);
    chk("none_count", int'(sol_count), 0);
    run_search(0, 255, 255, 0, NS);
    chk("all_count", int'(sol_count), 8);

    dummy = push_expected(25, 40, 50);
    min_value = 8'd25; max_weight = 8'd40; max_volume = 8'd50;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin m_val[i] = 0; m_wt[i] = 0; m_vol[i] = 0; end
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_valid", int'(sol_valid), 0);
    chk("midrst_count", int'(sol_count), 0);
    run_search(1, 255, 255, 0, NS);
    chk("zero_table_count", int'(sol_count), 0);
    load_basic();
    run_search(25, 40, 50, 0, NS);
    chk("reload_count", int'(sol_count), 3);

    run_search(25, 40, 50, 3, NS);
    chk("ignored_ctrl_count", int'(sol_count), 3);
    run_search(25, 40, 50, 0, NS);

    repeat (20) begin
      for (int i = 0; i < N; i++)
        load(i, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      run_search($urandom_range(0, 93), $urandom_range(0, 93), $urandom_range(0, 93), 1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/knap_search_multi.md
Name: knap_search_multi

Overview:
- Sequential exhaustive searcher for the multi-constraint 0/1 knapsack problem. It produces candidate item selections, where the existing combinational checkers only accept them.
- Walks all 2^N selections in Gray-code order, updating value/weight/volume totals incrementally (one add or subtract per cycle).
- Streams every selection meeting min_value / max_weight / max_volume out over a valid/ready handshake, and reports the solution count.
- Sits between a host loader (item table, thresholds) and downstream solution consumers.

Parameters:
- N, 17, number of items (selection width).
- W, 5, bit width of each per-item value/weight/volume entry.
- TW, 10, width of totals and thresholds; must satisfy 2^TW > N*(2^W-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- ld_en  input  1  item-table write strobe; honoured only in IDLE or DONE.
- ld_idx  input  clog2(N)  item index to write; idx >= N is ignored.
- ld_value  input  W  item value.
- ld_weight  input  W  item weight.
- ld_volume  input  W  item volume.
- min_value  input  TW  value lower bound (inclusive); sampled on start.
- max_weight  input  TW  weight upper bound (inclusive); sampled on start.
- max_volume  input  TW  volume upper bound (inclusive); sampled on start.
- start  input  1  begin search; honoured only in IDLE or DONE.
- busy  output  1  high in RUN.
- done  output  1  high in DONE (level).
- sol_valid  output  1  solution register holds a valid selection.
- sol_ready  input  1  consumer accepts when sol_valid && sol_ready.
- sol_sel  output  N  selection bit vector; bit i = item i taken.
- sol_count  output  N+1  number of solutions found in the current or last search.

Behaviour:
- Reset: state=IDLE; item table cleared to 0; busy=0, done=0, sol_valid=0, sol_sel=0, sol_count=0; totals=0. Reset during RUN aborts immediately with the same values. Any pending solution is dropped.
- States:
  - IDLE -> RUN on start.
  - RUN -> DONE after the last candidate is resolved.
  - DONE -> RUN on start. DONE otherwise holds.
- Start (IDLE/DONE): latch thresholds; sel=0, step=0, totals=0, sol_count=0, sol_valid=0; next cycle is RUN. ld_en on the same cycle as start is applied first.
- ld_en in RUN is ignored.
- Candidate check (combinational on registered totals): hit = tot_value >= min_value && tot_weight <= max_weight && tot_volume <= max_volume. All comparisons unsigned, TW bits; no wrap by parameter rule.
- Emit rule: slot_free = !sol_valid || sol_ready.
- Each RUN cycle:
  - If hit && !slot_free: stall. sel, totals and step hold.
  - Otherwise, if hit: load sol_sel=sel, sol_valid=1, and increment sol_count.
  - Then, if step == 2^N-1, go to DONE. Otherwise step+=1 and flip bit j = count-trailing-zeros(step+1) of sel. Add that item's triple to the totals if the bit becomes 1, subtract it if the bit becomes 0.
- Throughput: one candidate per cycle without backpressure. Selection 0 (empty) is evaluated first. RUN lasts 2^N cycles plus stall cycles.
- Output handshake: sol_valid clears on acceptance unless it is reloaded in the same cycle (simultaneous accept + new hit gives back-to-back valid). sol_sel is stable while sol_valid && !sol_ready.
- A solution may still be pending after entering DONE. It drains normally; done does not wait for it.
- sol_count holds its value in DONE until the next start.
- Ordering: solutions are emitted in Gray-code order of discovery and are never reordered or dropped.

Test Plan:
- Basic search, N=3, W=5, TW=8. Items: 0=(v10,w5,vol5), 1=(v20,w30,vol10), 2=(v15,w10,vol40). min_value=25, max_weight=40, max_volume=50. sol_ready=1, start. Required response:
  - sol_sel sequence 3'b011, 3'b110, 3'b101 (exact inclusive-boundary hits on 110 and 101).
  - sol_count=3.
  - done rises exactly 8 cycles after busy rises.
- Backpressure: same setup with sol_ready=0 until 10 cycles after start. Required response:
  - sol_sel=011 held stable the whole time.
  - Enumeration stalls at candidate 110.
  - After release, 110 then 101 arrive in order, with the same sol_count=3.
- No solutions: min_value=100, same items -> sol_valid never asserts, sol_count=0, done after 8 cycles.
- All pass: thresholds 0/255/255 -> 8 solutions in Gray order 000,001,011,010,110,111,101,100; sol_count=8.
- Reset mid-run: assert rst in cycle 4 of RUN. Required response:
  - Next cycle: busy=0, done=0, sol_valid=0, sol_count=0, table zeroed.
  - Reload and restart reproduces the basic-search result.
- Ignored controls: ld_en and start asserted during RUN -> table unchanged and no restart (basic-search result unchanged). Then a restart from DONE works.
